// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared widths, constants, fetch FSM state type and small
//                address helpers for the instruction-fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  // Sequential address of the next word; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] pc_plus4(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(4);
  endfunction

  // A fetch address is misaligned when either of its byte-offset bits is set.
  function automatic logic misaligned(input logic [1:0] low_bits);
    return |low_bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Bundle of PC-register, decode, instruction-memory and IF/ID
//                signals around the fetch stage. master = fetch unit side,
//                slave = surrounding pipeline / memory side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
  import cpu_pkg::*;

  logic [ADDR_W-1:0]  pc;
  logic               redirect;
  logic               id_stall;
  logic               pc_en;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               ifid_valid;
  logic [INSTR_W-1:0] ifid_instr;
  logic [ADDR_W-1:0]  ifid_pc;
  logic [ADDR_W-1:0]  ifid_pc4;
  logic               ifid_misalgn;

  modport master (
    input  pc, redirect, id_stall, imem_gnt, imem_rvalid, imem_rdata,
    output pc_en, imem_req, imem_addr,
           ifid_valid, ifid_instr, ifid_pc, ifid_pc4, ifid_misalgn
  );

  modport slave (
    output pc, redirect, id_stall, imem_gnt, imem_rvalid, imem_rdata,
    input  pc_en, imem_req, imem_addr,
           ifid_valid, ifid_instr, ifid_pc, ifid_pc4, ifid_misalgn
  );

endinterface
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_skid_buf
//  Description : One-entry holding register for a returned instruction that
//                could not enter IF/ID because decode was stalled.
//                Clear beats push; push beats pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid_buf
  import cpu_pkg::*;
(
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               push,
  input  wire logic               pop,
  input  wire logic               clear,
  input  wire logic [INSTR_W-1:0] in_instr,
  input  wire logic [ADDR_W-1:0]  in_pc,
  input  wire logic               in_misalgn,
  output logic                    full,
  output logic [INSTR_W-1:0]      out_instr,
  output logic [ADDR_W-1:0]       out_pc,
  output logic                    out_misalgn
);

  logic               r_full;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_pc;
  logic               r_misalgn;

  // Occupancy and payload of the single entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full    <= 1'b0;
      r_instr   <= NOP;
      r_pc      <= '0;
      r_misalgn <= 1'b0;
    end else if (clear) begin
      r_full    <= 1'b0;
    end else if (push) begin
      r_full    <= 1'b1;
      r_instr   <= in_instr;
      r_pc      <= in_pc;
      r_misalgn <= in_misalgn;
    end else if (pop) begin
      r_full    <= 1'b0;
    end
  end

  assign full        = r_full;
  assign out_instr   = r_instr;
  assign out_pc      = r_pc;
  assign out_misalgn = r_misalgn;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage. Issues one instruction-memory
//                request at a time for the current pc, parks the returned word
//                in IF/ID (or a 1-entry skid when decode stalls), advances the
//                PC register on grant and squashes in-flight work on redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import cpu_pkg::*;
(
  input  wire logic    clk,
  input  wire logic    rst,
  fetch_unit_if.master bus
);

  fetch_state_t       r_state;
  logic               r_req;
  logic               r_drop;
  logic [ADDR_W-1:0]  r_tag;

  logic               r_ifid_valid;
  logic [INSTR_W-1:0] r_ifid_instr;
  logic [ADDR_W-1:0]  r_ifid_pc;
  logic [ADDR_W-1:0]  r_ifid_pc4;
  logic               r_ifid_misalgn;

  logic               w_free;
  logic               w_gnt_take;
  logic               w_rv_take;
  logic               w_skid_push;
  logic               w_skid_pop;
  logic               w_skid_full;
  logic [INSTR_W-1:0] w_skid_instr;
  logic [ADDR_W-1:0]  w_skid_pc;
  logic               w_skid_misalgn;

  // Decode is free to take new IF/ID contents when it is empty or not stalled.
  assign w_free      = !r_ifid_valid || !bus.id_stall;
  assign w_gnt_take  = (r_state == REQ) && bus.imem_gnt;
  // A response counts only while a request is outstanding, not squashed, and
  // not coinciding with a redirect.
  assign w_rv_take   = bus.imem_rvalid && (r_state == WAIT) && !r_drop && !bus.redirect;
  assign w_skid_push = w_rv_take && !w_free;
  assign w_skid_pop  = w_skid_full && w_free && !bus.redirect;

  fetch_skid_buf u_skid (
    .clk         (clk),
    .rst         (rst),
    .push        (w_skid_push),
    .pop         (w_skid_pop),
    .clear       (bus.redirect),
    .in_instr    (bus.imem_rdata),
    .in_pc       (r_tag),
    .in_misalgn  (misaligned(r_tag[1:0])),
    .full        (w_skid_full),
    .out_instr   (w_skid_instr),
    .out_pc      (w_skid_pc),
    .out_misalgn (w_skid_misalgn)
  );

  // Request FSM with registered imem_req, drop flag and in-flight tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_drop  <= 1'b0;
      r_tag   <= '0;
    end else if (bus.redirect) begin
      unique case (r_state)
        REQ: begin
          if (bus.imem_gnt) begin
            // Granted request now points at the wrong stream: wait it out.
            r_tag   <= bus.pc;
            r_drop  <= 1'b1;
            r_state <= WAIT;
            r_req   <= 1'b0;
          end else begin
            r_state <= REQ;
            r_req   <= 1'b1;
          end
        end
        WAIT: begin
          if (bus.imem_rvalid) begin
            // The outstanding word returns now and is discarded here.
            r_drop  <= 1'b0;
            r_state <= REQ;
            r_req   <= 1'b1;
          end else begin
            r_drop  <= 1'b1;
            r_state <= WAIT;
            r_req   <= 1'b0;
          end
        end
        default: begin
          r_state <= REQ;
          r_req   <= 1'b1;
        end
      endcase
    end else begin
      unique case (r_state)
        IDLE: begin
          r_state <= REQ;
          r_req   <= 1'b1;
        end
        REQ: begin
          if (bus.imem_gnt) begin
            r_tag   <= bus.pc;
            r_state <= WAIT;
            r_req   <= 1'b0;
          end
        end
        WAIT: begin
          if (bus.imem_rvalid) begin
            r_drop <= 1'b0;
            if (!r_drop && !w_free) begin
              r_state <= HOLD;
              r_req   <= 1'b0;
            end else begin
              r_state <= REQ;
              r_req   <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (w_skid_pop) begin
            r_state <= REQ;
            r_req   <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  // IF/ID pipeline register: skid has priority over a fresh response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ifid_valid   <= 1'b0;
      r_ifid_instr   <= NOP;
      r_ifid_pc      <= '0;
      r_ifid_pc4     <= '0;
      r_ifid_misalgn <= 1'b0;
    end else if (bus.redirect) begin
      r_ifid_valid   <= 1'b0;
      r_ifid_instr   <= NOP;
    end else if (w_skid_pop) begin
      r_ifid_valid   <= 1'b1;
      r_ifid_instr   <= w_skid_instr;
      r_ifid_pc      <= w_skid_pc;
      r_ifid_pc4     <= pc_plus4(w_skid_pc);
      r_ifid_misalgn <= w_skid_misalgn;
    end else if (w_rv_take && w_free) begin
      r_ifid_valid   <= 1'b1;
      r_ifid_instr   <= bus.imem_rdata;
      r_ifid_pc      <= r_tag;
      r_ifid_pc4     <= pc_plus4(r_tag);
      r_ifid_misalgn <= misaligned(r_tag[1:0]);
    end else if (w_free) begin
      r_ifid_valid   <= 1'b0;
    end
  end

  // pc_en follows the grant combinationally so the PC advances in the same
  // edge that accepts its request; reset forces it low.
  assign bus.pc_en        = !rst && (w_gnt_take || bus.redirect);
  assign bus.imem_req     = r_req;
  assign bus.imem_addr    = {bus.pc[ADDR_W-1:2], 2'b00};
  assign bus.ifid_valid   = r_ifid_valid;
  assign bus.ifid_instr   = r_ifid_instr;
  assign bus.ifid_pc      = r_ifid_pc;
  assign bus.ifid_pc4     = r_ifid_pc4;
  assign bus.ifid_misalgn = r_ifid_misalgn;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit: a per-cycle
//                vector table for the basic 1-cycle-memory loop, followed by
//                hand-written stall, redirect, wrap/misalignment and
//                mid-request reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  fetch_unit_if bus();

  fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        stall;
    logic        redir;
    logic        e_pc_en;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [15:0] e_ifid_pc;
    logic [15:0] e_pc4;
    logic [31:0] e_instr;
  } vec_t;

  vec_t tbl [8];

  function automatic logic [31:0] iw(input int k);
    return 32'hC0DE_0000 + 32'(k);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs at the falling edge; outputs settle 1 time unit later.
  task automatic drive(input logic [15:0] pc, input logic gnt, input logic rv,
                       input logic [31:0] rd, input logic st, input logic rdr);
    @(negedge clk);
    bus.pc          = pc;
    bus.imem_gnt    = gnt;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rd;
    bus.id_stall    = st;
    bus.redirect    = rdr;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.pc = '0; bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = '0;
    bus.id_stall = 0; bus.redirect = 0;

    //             pc     gnt rv rdata   st rd | pen req addr   v  ifid_pc pc4     instr
    tbl[0] = '{16'h0000, 0, 0, 32'h0,   0, 0,  0,  0, 16'h0000, 0, 16'h0000, 16'h0000, NOP};
    tbl[1] = '{16'h0000, 1, 0, 32'h0,   0, 0,  1,  1, 16'h0000, 0, 16'h0000, 16'h0000, NOP};
    tbl[2] = '{16'h0004, 0, 1, iw(0),   0, 0,  0,  0, 16'h0004, 0, 16'h0000, 16'h0000, NOP};
    tbl[3] = '{16'h0004, 1, 0, 32'h0,   0, 0,  1,  1, 16'h0004, 1, 16'h0000, 16'h0004, iw(0)};
    tbl[4] = '{16'h0008, 0, 1, iw(1),   0, 0,  0,  0, 16'h0008, 0, 16'h0000, 16'h0004, iw(0)};
    tbl[5] = '{16'h0008, 1, 0, 32'h0,   0, 0,  1,  1, 16'h0008, 1, 16'h0004, 16'h0008, iw(1)};
    tbl[6] = '{16'h000C, 0, 1, iw(2),   0, 0,  0,  0, 16'h000C, 0, 16'h0004, 16'h0008, iw(1)};
    tbl[7] = '{16'h000C, 0, 0, 32'h0,   0, 0,  0,  1, 16'h000C, 1, 16'h0008, 16'h000C, iw(2)};

    // Reset state, with a redirect asserted that must not leak to pc_en.
    drive(16'h0000, 0, 0, 32'h0, 0, 1);
    chk("rst_pc_en",   32'(bus.pc_en), 0);
    chk("rst_req",     32'(bus.imem_req), 0);
    chk("rst_valid",   32'(bus.ifid_valid), 0);
    chk("rst_instr",   bus.ifid_instr, NOP);
    chk("rst_pc",      32'(bus.ifid_pc), 0);
    chk("rst_pc4",     32'(bus.ifid_pc4), 0);
    chk("rst_misalgn", 32'(bus.ifid_misalgn), 0);
    bus.redirect = 0;
    @(posedge clk);
    #1 rst = 1'b0;

    // 1: 1-cycle memory, pc = 0, 4, 8.
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].pc, tbl[i].gnt, tbl[i].rvalid, tbl[i].rdata, tbl[i].stall, tbl[i].redir);
      chk($sformatf("t1_pc_en[%0d]", i),   32'(bus.pc_en), 32'(tbl[i].e_pc_en));
      chk($sformatf("t1_req[%0d]", i),     32'(bus.imem_req), 32'(tbl[i].e_req));
      chk($sformatf("t1_addr[%0d]", i),    32'(bus.imem_addr), 32'(tbl[i].e_addr));
      chk($sformatf("t1_valid[%0d]", i),   32'(bus.ifid_valid), 32'(tbl[i].e_valid));
      chk($sformatf("t1_ifid_pc[%0d]", i), 32'(bus.ifid_pc), 32'(tbl[i].e_ifid_pc));
      chk($sformatf("t1_pc4[%0d]", i),     32'(bus.ifid_pc4), 32'(tbl[i].e_pc4));
      chk($sformatf("t1_instr[%0d]", i),   bus.ifid_instr, tbl[i].e_instr);
    end

    // 2: decode stall with a word in flight goes through the skid.
    drive(16'h000C, 1, 0, 32'h0, 0, 0);
    chk("t2_valid_dropped", 32'(bus.ifid_valid), 0);
    chk("t2_pc_en_gnt",     32'(bus.pc_en), 1);
    drive(16'h0010, 0, 1, iw(3), 0, 0);
    drive(16'h0010, 1, 0, 32'h0, 1, 0);
    chk("t2_valid_pre",     32'(bus.ifid_valid), 1);
    chk("t2_ifid_pc_pre",   32'(bus.ifid_pc), 32'h000C);
    chk("t2_instr_pre",     bus.ifid_instr, iw(3));
    drive(16'h0014, 0, 1, iw(4), 1, 0);
    drive(16'h0014, 0, 0, 32'h0, 1, 0);
    chk("t2_state_hold",    32'(dut.r_state), 32'(HOLD));
    chk("t2_req_hold",      32'(bus.imem_req), 0);
    chk("t2_skid_full",     32'(dut.u_skid.full), 1);
    chk("t2_ifid_pc_held",  32'(bus.ifid_pc), 32'h000C);
    drive(16'h0014, 0, 0, 32'h0, 1, 0);
    chk("t2_req_hold2",     32'(bus.imem_req), 0);
    chk("t2_pc_en_hold",    32'(bus.pc_en), 0);
    drive(16'h0014, 0, 0, 32'h0, 0, 0);
    chk("t2_ifid_pc_rel",   32'(bus.ifid_pc), 32'h000C);
    drive(16'h0014, 0, 0, 32'h0, 0, 0);
    chk("t2_valid_skid",    32'(bus.ifid_valid), 1);
    chk("t2_ifid_pc_skid",  32'(bus.ifid_pc), 32'h0010);
    chk("t2_instr_skid",    bus.ifid_instr, iw(4));
    chk("t2_pc4_skid",      32'(bus.ifid_pc4), 32'h0014);
    chk("t2_req_after",     32'(bus.imem_req), 1);
    chk("t2_addr_after",    32'(bus.imem_addr), 32'h0014);
    chk("t2_skid_empty",    32'(dut.u_skid.full), 0);
    drive(16'h0014, 0, 0, 32'h0, 0, 0);
    chk("t2_no_dup",        32'(bus.ifid_valid), 0);

    // 3: redirect while waiting on a 3-cycle memory.
    drive(16'h0014, 1, 0, 32'h0, 0, 0);
    drive(16'h0018, 0, 0, 32'h0, 0, 1);
    chk("t3_pc_en_redir",   32'(bus.pc_en), 1);
    drive(16'h0100, 0, 0, 32'h0, 0, 0);
    chk("t3_req_wait",      32'(bus.imem_req), 0);
    chk("t3_valid_wait",    32'(bus.ifid_valid), 0);
    drive(16'h0100, 0, 1, iw(5), 0, 0);
    chk("t3_req_late",      32'(bus.imem_req), 0);
    drive(16'h0100, 1, 0, 32'h0, 0, 0);
    chk("t3_req_new",       32'(bus.imem_req), 1);
    chk("t3_addr_new",      32'(bus.imem_addr), 32'h0100);
    chk("t3_valid_dropped", 32'(bus.ifid_valid), 0);
    drive(16'h0104, 0, 1, iw(6), 0, 0);
    chk("t3_valid_still0",  32'(bus.ifid_valid), 0);
    drive(16'h0104, 0, 0, 32'h0, 1, 0);
    chk("t3_valid_new",     32'(bus.ifid_valid), 1);
    chk("t3_ifid_pc_new",   32'(bus.ifid_pc), 32'h0100);
    chk("t3_instr_new",     bus.ifid_instr, iw(6));

    // 4: redirect together with rvalid and id_stall.
    drive(16'h0104, 1, 0, 32'h0, 1, 0);
    chk("t4_valid_pre",     32'(bus.ifid_valid), 1);
    drive(16'h0108, 0, 1, iw(7), 1, 1);
    chk("t4_pc_en",         32'(bus.pc_en), 1);
    drive(16'h0200, 1, 0, 32'h0, 0, 0);
    chk("t4_valid_clr",     32'(bus.ifid_valid), 0);
    chk("t4_instr_nop",     bus.ifid_instr, NOP);
    chk("t4_state_req",     32'(dut.r_state), 32'(REQ));
    chk("t4_skid_empty",    32'(dut.u_skid.full), 0);
    chk("t4_req",           32'(bus.imem_req), 1);
    chk("t4_addr",          32'(bus.imem_addr), 32'h0200);
    drive(16'h0204, 0, 1, iw(8), 0, 0);

    // 5: address wrap and misaligned pc.
    drive(16'hFFFC, 1, 0, 32'h0, 0, 0);
    chk("t4_after_valid",   32'(bus.ifid_valid), 1);
    chk("t4_after_pc",      32'(bus.ifid_pc), 32'h0200);
    chk("t4_after_instr",   bus.ifid_instr, iw(8));
    drive(16'h0000, 0, 1, iw(9), 0, 0);
    drive(16'h0006, 1, 0, 32'h0, 0, 0);
    chk("t5_wrap_pc",       32'(bus.ifid_pc), 32'hFFFC);
    chk("t5_wrap_pc4",      32'(bus.ifid_pc4), 32'h0000);
    chk("t5_wrap_misalgn",  32'(bus.ifid_misalgn), 0);
    chk("t5_mis_addr",      32'(bus.imem_addr), 32'h0004);
    drive(16'h000A, 0, 1, iw(10), 0, 0);
    drive(16'h000A, 1, 0, 32'h0, 0, 0);
    chk("t5_mis_flag",      32'(bus.ifid_misalgn), 1);
    chk("t5_mis_instr",     bus.ifid_instr, iw(10));

    // 6: asynchronous reset in the middle of a WAIT.
    drive(16'h000E, 0, 0, 32'h0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("t6_req",           32'(bus.imem_req), 0);
    chk("t6_valid",         32'(bus.ifid_valid), 0);
    chk("t6_instr",         bus.ifid_instr, NOP);
    chk("t6_pc",            32'(bus.ifid_pc), 0);
    chk("t6_pc4",           32'(bus.ifid_pc4), 0);
    chk("t6_misalgn",       32'(bus.ifid_misalgn), 0);
    chk("t6_state",         32'(dut.r_state), 32'(IDLE));
    @(posedge clk);
    drive(16'h0040, 0, 1, iw(11), 0, 0);
    rst = 1'b0;
    #1;
    chk("t6_idle_req",      32'(bus.imem_req), 0);
    drive(16'h0040, 1, 1, iw(11), 0, 0);
    chk("t6_restart_req",   32'(bus.imem_req), 1);
    chk("t6_restart_addr",  32'(bus.imem_addr), 32'h0040);
    chk("t6_stray_ignored", 32'(bus.ifid_valid), 0);
    drive(16'h0044, 0, 1, iw(12), 0, 0);
    chk("t6_stray_ignored2", 32'(bus.ifid_valid), 0);
    drive(16'h0044, 0, 0, 32'h0, 0, 0);
    chk("t6_valid",         32'(bus.ifid_valid), 1);
    chk("t6_ifid_pc",       32'(bus.ifid_pc), 32'h0040);
    chk("t6_ifid_instr",    bus.ifid_instr, iw(12));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
